// File: rtl/instr_push_loader_pkg.sv
// Shared widths, opcode constants and FSM encoding for the instruction push loader.
package instr_push_loader_pkg;
    localparam int DEF_INSTR_WIDTH      = 32;
    localparam int DEF_INSTR_MEM_AWIDTH = 10;
    localparam int DEF_OPCODE_WIDTH     = 4;
    localparam int DEF_START_THRESH     = 4;
    localparam logic [DEF_OPCODE_WIDTH-1:0] DEF_END_CHAIN_OPCODE = 4'hF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } loader_state_t;
endpackage

// File: rtl/loader_ring_ctrl.sv
// Ring-buffer bookkeeping: pointers, committed count, in-flight write, ready and error flags.
module loader_ring_ctrl #(
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          reset_npu,
    input  logic          accept,
    input  logic          done,
    input  logic          get_instr,
    input  logic [AW-1:0] get_instr_addr,
    output logic [AW-1:0] wr_ptr,
    output logic [AW-1:0] rd_ptr,
    output logic [AW:0]   count,
    output logic [AW:0]   count_nxt,
    output logic          pending,
    output logic          push_ready,
    output logic          err_underflow,
    output logic          err_order
);
    // 2**AW expressed at occupancy width
    localparam logic [AW+1:0] DEPTH = {1'b0, 1'b1, {AW{1'b0}}};

    logic          dec;
    logic [AW+1:0] occ;

    // Next committed count; a consume of an empty buffer never decrements
    always_comb begin
        dec       = get_instr && (count != '0);
        count_nxt = count;
        if (pending && !dec)
            count_nxt = count + 1'b1;
        else if (!pending && dec)
            count_nxt = count - 1'b1;
        occ        = {1'b0, count} + {{(AW+1){1'b0}}, pending};
        push_ready = (occ < DEPTH) && !done;
    end

    // Pointer, count, in-flight and sticky error registers
    always_ff @(posedge clk) begin
        if (reset_npu) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            pending       <= 1'b0;
            err_underflow <= 1'b0;
            err_order     <= 1'b0;
        end else begin
            pending <= accept;
            count   <= count_nxt;
            if (accept)
                wr_ptr <= wr_ptr + 1'b1;
            if (get_instr) begin
                rd_ptr <= rd_ptr + 1'b1;
                if (count == '0)
                    err_underflow <= 1'b1;
                if (get_instr_addr != rd_ptr)
                    err_order <= 1'b1;
            end
        end
    end
endmodule

// File: rtl/instr_push_loader.sv
// Host-side writer for NPU instruction memory port B with start/done sequencing.
module instr_push_loader
    import instr_push_loader_pkg::*;
#(
    parameter int INSTR_WIDTH      = DEF_INSTR_WIDTH,
    parameter int INSTR_MEM_AWIDTH = DEF_INSTR_MEM_AWIDTH,
    parameter int OPCODE_WIDTH     = DEF_OPCODE_WIDTH,
    parameter logic [OPCODE_WIDTH-1:0] END_CHAIN_OPCODE = DEF_END_CHAIN_OPCODE,
    parameter int START_THRESH     = DEF_START_THRESH
) (
    input  logic                        clk,
    input  logic                        reset_npu,
    input  logic                        push_valid,
    input  logic [INSTR_WIDTH-1:0]      push_instruction,
    output logic                        push_ready,
    output logic                        push_instr_enable,
    output logic [INSTR_MEM_AWIDTH-1:0] push_instr_addr,
    output logic [INSTR_WIDTH-1:0]      push_instr_data,
    input  logic                        get_instr,
    input  logic [INSTR_MEM_AWIDTH-1:0] get_instr_addr,
    output logic                        instr_avail,
    output logic [INSTR_MEM_AWIDTH:0]   instr_count,
    output logic                        npu_start,
    output logic                        prog_done,
    output logic                        err_underflow,
    output logic                        err_order
);
    localparam int AW = INSTR_MEM_AWIDTH;
    localparam logic [AW:0] THRESH = (AW+1)'(START_THRESH);

    loader_state_t state, state_nxt;
    logic          accept, is_end, end_commit, end_consume;
    logic          end_pending;
    logic [AW-1:0] end_addr, wr_ptr, rd_ptr;
    logic [AW:0]   count_nxt;

    assign accept = push_valid && push_ready;
    assign is_end = push_instruction[INSTR_WIDTH-1 -: OPCODE_WIDTH] == END_CHAIN_OPCODE;

    loader_ring_ctrl #(.AW(AW)) u_ring (
        .clk            (clk),
        .reset_npu      (reset_npu),
        .accept         (accept),
        .done           (state == DONE),
        .get_instr      (get_instr),
        .get_instr_addr (get_instr_addr),
        .wr_ptr         (wr_ptr),
        .rd_ptr         (rd_ptr),
        .count          (instr_count),
        .count_nxt      (count_nxt),
        .pending        (push_instr_enable),
        .push_ready     (push_ready),
        .err_underflow  (err_underflow),
        .err_order      (err_order)
    );

    assign instr_avail = instr_count != '0;
    assign prog_done   = state == DONE;

    // The recorded END_CHAIN entry lands in memory, or is consumed by the NPU
    assign end_commit  = push_instr_enable && end_pending && (push_instr_addr == end_addr);
    assign end_consume = get_instr && end_pending && (get_instr_addr == end_addr);

    // Next-state: start once enough is committed or a short program is complete
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = LOAD;
            LOAD:    if (count_nxt >= THRESH || end_commit) state_nxt = RUN;
            RUN:     if (end_consume) state_nxt = DONE;
            default: state_nxt = state;
        endcase
    end

    // State register and single-cycle start pulse
    always_ff @(posedge clk) begin
        if (reset_npu) begin
            state     <= IDLE;
            npu_start <= 1'b0;
        end else begin
            state     <= state_nxt;
            npu_start <= (state == LOAD) && (state_nxt == RUN);
        end
    end

    // Port B address/data capture and first-END_CHAIN bookkeeping
    always_ff @(posedge clk) begin
        if (reset_npu) begin
            push_instr_addr <= '0;
            push_instr_data <= '0;
            end_addr        <= '0;
            end_pending     <= 1'b0;
        end else if (accept) begin
            push_instr_addr <= wr_ptr;
            push_instr_data <= push_instruction;
            if (is_end && !end_pending) begin
                end_addr    <= wr_ptr;
                end_pending <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_instr_push_loader.sv
// Directed bench for instr_push_loader with an 8-entry ring and start threshold of 4.
module tb_instr_push_loader;
    logic        clk = 1'b0;
    logic        reset_npu = 1'b1;
    logic        push_valid = 1'b0;
    logic [31:0] push_instruction = '0;
    logic        push_ready, push_instr_enable;
    logic [2:0]  push_instr_addr;
    logic [31:0] push_instr_data;
    logic        get_instr = 1'b0;
    logic [2:0]  get_instr_addr = '0;
    logic        instr_avail;
    logic [3:0]  instr_count;
    logic        npu_start, prog_done, err_underflow, err_order;

    int tests = 0;
    int fails = 0;

    instr_push_loader #(.INSTR_MEM_AWIDTH(3), .START_THRESH(4)) dut (
        .clk(clk), .reset_npu(reset_npu),
        .push_valid(push_valid), .push_instruction(push_instruction), .push_ready(push_ready),
        .push_instr_enable(push_instr_enable), .push_instr_addr(push_instr_addr),
        .push_instr_data(push_instr_data),
        .get_instr(get_instr), .get_instr_addr(get_instr_addr),
        .instr_avail(instr_avail), .instr_count(instr_count),
        .npu_start(npu_start), .prog_done(prog_done),
        .err_underflow(err_underflow), .err_order(err_order)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset_npu = 1'b1; push_valid = 1'b0; get_instr = 1'b0;
        step(); step();
        reset_npu = 1'b0;
    endtask

    initial begin
        // reset state
        do_reset();
        chk("rst_ready", 32'(push_ready), 1);
        chk("rst_count", 32'(instr_count), 0);
        chk("rst_avail", 32'(instr_avail), 0);
        chk("rst_we", 32'(push_instr_enable), 0);
        chk("rst_start", 32'(npu_start), 0);
        chk("rst_done", 32'(prog_done), 0);
        chk("rst_errs", {30'd0, err_underflow, err_order}, 0);

        // four back-to-back pushes
        push_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            push_instruction = 32'h1000_0001 + 32'(i);
            step();
            chk("s1_we", 32'(push_instr_enable), 1);
            chk("s1_addr", 32'(push_instr_addr), 32'(i));
            chk("s1_data", push_instr_data, 32'h1000_0001 + 32'(i));
            chk("s1_start_early", 32'(npu_start), 0);
        end
        push_valid = 1'b0;
        step();
        chk("s1_count4", 32'(instr_count), 4);
        chk("s1_start", 32'(npu_start), 1);
        chk("s1_we_off", 32'(push_instr_enable), 0);
        step();
        chk("s1_start_pulse", 32'(npu_start), 0);
        chk("s1_ready", 32'(push_ready), 1);

        // short program ending in END_CHAIN
        do_reset();
        push_valid = 1'b1; push_instruction = 32'h1000_0001;
        step();
        push_instruction = 32'hF000_0002;
        step();
        chk("s2_start_wait", 32'(npu_start), 0);
        push_valid = 1'b0;
        step();
        chk("s2_start", 32'(npu_start), 1);
        chk("s2_count", 32'(instr_count), 2);
        get_instr = 1'b1; get_instr_addr = 3'd0;
        step();
        chk("s2_done_early", 32'(prog_done), 0);
        chk("s2_count1", 32'(instr_count), 1);
        get_instr_addr = 3'd1;
        step();
        get_instr = 1'b0;
        chk("s2_done", 32'(prog_done), 1);
        chk("s2_ready", 32'(push_ready), 0);
        chk("s2_count0", 32'(instr_count), 0);
        chk("s2_errs", {30'd0, err_underflow, err_order}, 0);
        step();
        chk("s2_done_hold", 32'(prog_done), 1);

        // fill, full stall, wrap
        do_reset();
        push_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("s3_ready_fill", 32'(push_ready), 1);
            push_instruction = 32'h2000_0000 + 32'(i);
            step();
        end
        push_instruction = 32'h2000_00AA;
        chk("s3_full_pending", 32'(push_ready), 0);
        step();
        chk("s3_full", 32'(push_ready), 0);
        chk("s3_count8", 32'(instr_count), 8);
        chk("s3_no_we", 32'(push_instr_enable), 0);
        get_instr = 1'b1; get_instr_addr = 3'd0;
        step();
        get_instr = 1'b0;
        chk("s3_ready_back", 32'(push_ready), 1);
        chk("s3_count7", 32'(instr_count), 7);
        chk("s3_still_no_we", 32'(push_instr_enable), 0);
        step();
        push_valid = 1'b0;
        chk("s3_wrap_we", 32'(push_instr_enable), 1);
        chk("s3_wrap_addr", 32'(push_instr_addr), 0);
        chk("s3_wrap_data", push_instr_data, 32'h2000_00AA);
        step();
        chk("s3_count8_again", 32'(instr_count), 8);
        chk("s3_full_again", 32'(push_ready), 0);

        // commit and consume on the same edge
        do_reset();
        push_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            push_instruction = 32'h3000_0000 + 32'(i);
            step();
        end
        push_valid = 1'b0;
        step();
        chk("s4_count3", 32'(instr_count), 3);
        push_valid = 1'b1; push_instruction = 32'h3000_0003;
        step();
        push_valid = 1'b0; get_instr = 1'b1; get_instr_addr = 3'd0;
        step();
        chk("s4_count_same", 32'(instr_count), 3);
        chk("s4_no_start", 32'(npu_start), 0);
        get_instr_addr = 3'd1;
        step();
        get_instr = 1'b0;
        chk("s4_count2", 32'(instr_count), 2);
        chk("s4_order_ok", 32'(err_order), 0);
        push_valid = 1'b1; push_instruction = 32'h3000_0004;
        step();
        push_valid = 1'b0;
        chk("s4_next_addr", 32'(push_instr_addr), 4);

        // underflow and ordering errors
        do_reset();
        get_instr = 1'b1; get_instr_addr = 3'd0;
        step();
        chk("s5_underflow", 32'(err_underflow), 1);
        chk("s5_count0", 32'(instr_count), 0);
        chk("s5_order_clean", 32'(err_order), 0);
        get_instr_addr = 3'd1;
        step();
        chk("s5_order_clean2", 32'(err_order), 0);
        get_instr_addr = 3'd5;
        step();
        get_instr = 1'b0;
        chk("s5_order", 32'(err_order), 1);
        step(); step();
        chk("s5_sticky", {30'd0, err_underflow, err_order}, 3);
        chk("s5_count_hold", 32'(instr_count), 0);

        // reset right after an accept
        do_reset();
        chk("s6_errs_cleared", {30'd0, err_underflow, err_order}, 0);
        push_valid = 1'b1; push_instruction = 32'hF000_0009;
        step();
        push_valid = 1'b0; reset_npu = 1'b1;
        step();
        reset_npu = 1'b0;
        chk("s6_we_dropped", 32'(push_instr_enable), 0);
        chk("s6_count", 32'(instr_count), 0);
        chk("s6_ready", 32'(push_ready), 1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("s6_no_start", 32'(npu_start), 0);
            chk("s6_no_we", 32'(push_instr_enable), 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/instr_push_loader.md
Name: instr_push_loader

Overview:
Host-side writer for the NPU instruction memory; the counterpart of the NPU fetch path, which reads port A through get_instr/get_instr_addr.
Accepts instructions from a host valid/ready stream and writes them into memory port B, treating the memory as a ring buffer.
Tracks NPU consumption and raises a one-cycle start pulse once enough of the program is committed.
Detects the END_CHAIN opcode at the consume side to report program completion.

Parameters:
INSTR_WIDTH, 32, instruction word width (matches `INSTR_WIDTH)
INSTR_MEM_AWIDTH, 10, instruction memory address width; DEPTH = 2**INSTR_MEM_AWIDTH
OPCODE_WIDTH, 4, opcode field width, located at the instruction MSBs
END_CHAIN_OPCODE, 4'hF, opcode value that terminates a program
START_THRESH, 4, committed-entry count that triggers npu_start

Ports:
clk  input  1  system clock
reset_npu  input  1  synchronous active-high reset
push_valid  input  1  host offers an instruction
push_instruction  input  INSTR_WIDTH  host instruction word
push_ready  output  1  loader can accept an instruction
push_instr_enable  output  1  port B write enable (web)
push_instr_addr  output  INSTR_MEM_AWIDTH  port B address (addrb)
push_instr_data  output  INSTR_WIDTH  port B write data (inb)
get_instr  input  1  NPU consumed the entry at get_instr_addr this cycle
get_instr_addr  input  INSTR_MEM_AWIDTH  NPU fetch address (addra)
instr_avail  output  1  committed count is nonzero
instr_count  output  INSTR_MEM_AWIDTH+1  committed, unconsumed entries
npu_start  output  1  one-cycle pulse on entry to RUN
prog_done  output  1  level; set when END_CHAIN is consumed
err_underflow  output  1  sticky; get_instr asserted while count is 0
err_order  output  1  sticky; get_instr_addr does not equal rd_ptr on a consume

Behaviour:
- Everything is synchronous to the clk rising edge. reset_npu clears all state:
  - wr_ptr, rd_ptr, count, pending all 0; state IDLE.
  - All outputs 0 except push_ready = 1.
  - Memory contents are not cleared.
- Reset mid-program aborts immediately. An in-flight write is dropped: push_instr_enable is 0 in the cycle after reset.
- Accept at edge k when push_valid && push_ready.
  - During cycle k+1: push_instr_enable=1, push_instr_addr=wr_ptr (value before increment), push_instr_data=word. All three are registered.
  - wr_ptr increments at edge k and wraps modulo DEPTH.
  - Memory writes at edge k+1; count increments at edge k+1. The entry is therefore visible to NPU reads from cycle k+2, so there is no read-during-write hazard.
- Occupancy: occ = count + pending, where pending = write in flight.
  - push_ready = (occ < DEPTH) && state != DONE, combinational from registers only.
  - push_ready must never depend on push_valid.
- Consume: get_instr at an edge decrements count and increments rd_ptr, wrapping modulo DEPTH.
  - If get_instr_addr != rd_ptr, set err_order; the consume still proceeds.
- Simultaneous commit and consume on one edge: count unchanged, both pointers advance.
- get_instr with count == 0 (including the cycle where a commit lands on the same edge):
  - Set err_underflow; no decrement; rd_ptr still advances.
  - The commit still increments count.
- END_CHAIN tracking:
  - On accept, if word[INSTR_WIDTH-1 -: OPCODE_WIDTH] == END_CHAIN_OPCODE, record end_addr and set end_pending. Only the first END_CHAIN is recorded.
  - A later END_CHAIN push is accepted but not recorded.
- FSM:
  - IDLE -> LOAD on the first accept.
  - LOAD -> RUN at the edge where committed count >= START_THRESH, or where the END_CHAIN entry commits (a program shorter than the threshold). npu_start=1 for exactly the cycle after that edge.
  - RUN: pushes continue.
  - RUN -> DONE on a consume with get_instr_addr == end_addr && end_pending. prog_done=1 from the following cycle.
  - DONE: push_ready=0; holds until reset_npu.
- Consumes in IDLE/LOAD are legal and use the same counting and error rules (NPU free-running); no state change.
- Error flags are sticky until reset.

Decomposition:
- Shared package/defines: INSTR_WIDTH, INSTR_MEM_AWIDTH, OPCODE_WIDTH, END_CHAIN opcode value, FSM state encodings (IDLE=0, LOAD=1, RUN=2, DONE=3).
- One sub-module, loader_ring_ctrl, holds pointers, count, pending, occupancy/ready, and the error flags.
- The top level holds the FSM, END_CHAIN detection, and port B output registers.

Test Plan:
- All scenarios use INSTR_MEM_AWIDTH=3, DEPTH=8, START_THRESH=4.
- Reset then 4 back-to-back pushes 0x10000001..0x10000004 -> port B writes at addr 0..3 in consecutive cycles; instr_count=4 two cycles after the last accept; single npu_start pulse; state RUN.
- Push 2 words, the second with opcode 0xF -> npu_start after the second commit; NPU consumes addr 0,1 -> prog_done=1 the cycle after consuming addr 1; push_ready=0.
- Fill 8 with no consumes -> push_ready=0 while occ=8; hold push_valid; one consume -> push_ready=1; next write goes to addr 0 (wrap); count returns to 8.
- Commit and consume on the same edge with count=3 -> count stays 3; rd_ptr and wr_ptr both advance.
- get_instr while count=0 -> err_underflow=1, count stays 0; get_instr_addr=5 while rd_ptr=2 -> err_order=1; both hold until reset.
- Assert reset_npu in the cycle after an accept -> no port B write next cycle; count=0, push_ready=1, npu_start never pulses.
